// File: rtl/udma_uart_rx_poller_if.sv
// udma_uart_rx_poller_if: uDMA UART config-bus request/response bundle.
// master drives data/addr/valid/rwn, slave returns read data and ready.
interface udma_uart_rx_poller_if;
  logic [31:0] cfg_data_o;
  logic [4:0]  cfg_addr_o;
  logic        cfg_valid_o;
  logic        cfg_rwn_o;
  logic [31:0] cfg_data_i;
  logic        cfg_ready_i;

  modport master (
    output cfg_data_o,
    output cfg_addr_o,
    output cfg_valid_o,
    output cfg_rwn_o,
    input  cfg_data_i,
    input  cfg_ready_i
  );

  modport slave (
    input  cfg_data_o,
    input  cfg_addr_o,
    input  cfg_valid_o,
    input  cfg_rwn_o,
    output cfg_data_i,
    output cfg_ready_i
  );
endinterface

// File: rtl/udma_uart_rx_poller.sv
// udma_uart_rx_poller: cfg-bus initiator that programs UART_SETUP, polls
// VALID/DATA into a byte FIFO and streams the bytes out.
// Ports: clk_i/rstn_i (async, active-low); start_i/stop_i/setup_i/busy_o
// session control; cfg master interface; rx_data_o/rx_valid_o/rx_ready_i
// byte stream; err_parity_o/err_overflow_o/err_clr_i sticky errors;
// fifo_level_o occupancy.
// Optional macro UART_POLL_ERR_EN enables periodic ERROR register reads.
module udma_uart_rx_poller #(
  parameter int FIFO_DEPTH      = 4,
  parameter int POLL_GAP        = 2,
  parameter int ERR_POLL_PERIOD = 16
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           start_i,
  input  logic                           stop_i,
  input  logic [31:0]                    setup_i,
  output logic                           busy_o,
  udma_uart_rx_poller_if.master          cfg,
  output logic [7:0]                     rx_data_o,
  output logic                           rx_valid_o,
  input  logic                           rx_ready_i,
  output logic                           err_parity_o,
  output logic                           err_overflow_o,
  input  logic                           err_clr_i,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  localparam logic [4:0] A_SETUP = 5'h09;
  localparam logic [4:0] A_ERROR = 5'h0A;
  localparam logic [4:0] A_VALID = 5'h0C;
  localparam logic [4:0] A_DATA  = 5'h0D;
  // en_rx (bit 9) and polling_en (bit 4)
  localparam logic [31:0] RX_EN = 32'h0000_0210;

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    GAP,
    RD_VALID,
    RD_DATA,
`ifdef UART_POLL_ERR_EN
    RD_ERR,
`endif
    WR_STOP
  } state_t;

  localparam state_t NEXT_POLL = (POLL_GAP == 0) ? RD_VALID : GAP;

  state_t        state;
  logic [31:0]   setup_q;
  logic [GW-1:0] gap_cnt;
  logic          stop_pend;
  logic          hs;
  logic          full;
  logic          push;
  logic          pop;
  logic          due_valid;
  logic          due_now;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;

  assign hs     = cfg.cfg_valid_o & cfg.cfg_ready_i;
  assign busy_o = (state != IDLE);

  always_comb begin
    cfg.cfg_valid_o = 1'b0;
    cfg.cfg_rwn_o   = 1'b0;
    cfg.cfg_addr_o  = 5'h00;
    cfg.cfg_data_o  = 32'h0;
    unique case (state)
      WR_SETUP: begin
        cfg.cfg_valid_o = 1'b1;
        cfg.cfg_addr_o  = A_SETUP;
        cfg.cfg_data_o  = setup_q;
      end
      RD_VALID: begin
        cfg.cfg_valid_o = 1'b1;
        cfg.cfg_rwn_o   = 1'b1;
        cfg.cfg_addr_o  = A_VALID;
      end
      RD_DATA: begin
        cfg.cfg_valid_o = 1'b1;
        cfg.cfg_rwn_o   = 1'b1;
        cfg.cfg_addr_o  = A_DATA;
      end
`ifdef UART_POLL_ERR_EN
      RD_ERR: begin
        cfg.cfg_valid_o = 1'b1;
        cfg.cfg_rwn_o   = 1'b1;
        cfg.cfg_addr_o  = A_ERROR;
      end
`endif
      WR_STOP: begin
        cfg.cfg_valid_o = 1'b1;
        cfg.cfg_addr_o  = A_SETUP;
        cfg.cfg_data_o  = setup_q & ~RX_EN;
      end
      default: ;
    endcase
  end

`ifdef UART_POLL_ERR_EN
  localparam int PW = $clog2(ERR_POLL_PERIOD + 1);

  logic [PW-1:0] poll_cnt;
  logic [PW-1:0] poll_inc;
  logic          par_q;
  logic          ovf_q;
  logic          err_hs;
  logic          unused_ok;

  assign poll_inc = (poll_cnt == {PW{1'b1}}) ?
                    poll_cnt : poll_cnt + 1'b1;
  // RD_VALID judges the count including the poll just finished
  assign due_valid = (poll_inc >= PW'(ERR_POLL_PERIOD));
  assign due_now   = (poll_cnt >= PW'(ERR_POLL_PERIOD));
  assign err_hs    = (state == RD_ERR) & hs;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      poll_cnt <= '0;
      par_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if ((state == RD_VALID) && hs)
        poll_cnt <= poll_inc;
      if (err_hs)
        poll_cnt <= '0;
      // a new error in the clearing cycle survives
      par_q <= (par_q & ~err_clr_i) |
               (err_hs & cfg.cfg_data_i[1]);
      ovf_q <= (ovf_q & ~err_clr_i) |
               (err_hs & cfg.cfg_data_i[0]);
    end
  end

  assign err_parity_o   = par_q;
  assign err_overflow_o = ovf_q;
  assign unused_ok      = ^cfg.cfg_data_i[31:8];
`else
  logic unused_ok;

  assign due_valid      = 1'b0;
  assign due_now        = 1'b0;
  assign err_parity_o   = 1'b0;
  assign err_overflow_o = 1'b0;
  assign unused_ok      = ^{cfg.cfg_data_i[31:8], err_clr_i,
                            due_valid, due_now};
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      setup_q   <= 32'h0;
      gap_cnt   <= '0;
      stop_pend <= 1'b0;
    end else begin
      if (stop_i && (state != IDLE))
        stop_pend <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            setup_q <= setup_i | RX_EN;
            state   <= WR_SETUP;
          end
        end
        WR_SETUP: begin
          if (hs)
            state <= NEXT_POLL;
        end
        GAP: begin
          if (stop_pend) begin
            gap_cnt <= '0;
            state   <= WR_STOP;
          end else if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= RD_VALID;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        RD_VALID: begin
          if (hs) begin
            if (stop_pend)
              state <= WR_STOP;
            // a full FIFO leaves the byte in the target
            else if (cfg.cfg_data_i[0] && !full)
              state <= RD_DATA;
`ifdef UART_POLL_ERR_EN
            else if (due_valid)
              state <= RD_ERR;
`endif
            else
              state <= NEXT_POLL;
          end
        end
        RD_DATA: begin
          if (hs) begin
            if (stop_pend)
              state <= WR_STOP;
`ifdef UART_POLL_ERR_EN
            else if (due_now)
              state <= RD_ERR;
`endif
            else
              state <= NEXT_POLL;
          end
        end
`ifdef UART_POLL_ERR_EN
        RD_ERR: begin
          if (hs)
            state <= stop_pend ? WR_STOP : NEXT_POLL;
        end
`endif
        WR_STOP: begin
          if (hs) begin
            state     <= IDLE;
            stop_pend <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign full       = (level == LW'(FIFO_DEPTH));
  assign rx_valid_o = (level != '0);
  assign push       = (state == RD_DATA) & hs;
  assign pop        = rx_valid_o & rx_ready_i;
  assign rx_data_o  = mem[rd_ptr];
  assign fifo_level_o = level;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= 8'h00;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= cfg.cfg_data_i[7:0];
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_udma_uart_rx_poller.sv
// tb_udma_uart_rx_poller: directed bench with a behavioural UART register
// target on the cfg bus and a log of every completed cfg transfer.
module tb_udma_uart_rx_poller;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        start_i;
  logic        stop_i;
  logic [31:0] setup_i;
  logic        busy_o;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic        err_parity_o;
  logic        err_overflow_o;
  logic        err_clr_i;
  logic [2:0]  fifo_level_o;

  always #5 clk_i = ~clk_i;

  udma_uart_rx_poller_if cfg ();

  udma_uart_rx_poller dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .start_i        (start_i),
    .stop_i         (stop_i),
    .setup_i        (setup_i),
    .busy_o         (busy_o),
    .cfg            (cfg),
    .rx_data_o      (rx_data_o),
    .rx_valid_o     (rx_valid_o),
    .rx_ready_i     (rx_ready_i),
    .err_parity_o   (err_parity_o),
    .err_overflow_o (err_overflow_o),
    .err_clr_i      (err_clr_i),
    .fifo_level_o   (fifo_level_o)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic        tgt_ready;
  logic [31:0] tgt_err;
  logic [7:0]  tgt_bytes [64];
  int          tgt_wr = 0;
  int          tgt_rd = 0;

  logic [4:0]  log_addr [1024];
  logic        log_rwn  [1024];
  logic [31:0] log_data [1024];
  int          log_cyc  [1024];
  int          n_log = 0;

  assign cfg.cfg_ready_i = tgt_ready;
  assign cfg.cfg_data_i =
    (cfg.cfg_addr_o == 5'h0C) ? {31'd0, (tgt_wr != tgt_rd)} :
    (cfg.cfg_addr_o == 5'h0D) ? {24'd0, tgt_bytes[tgt_rd & 63]} :
    (cfg.cfg_addr_o == 5'h0A) ? tgt_err : 32'd0;

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (cfg.cfg_valid_o && cfg.cfg_ready_i) begin
      if (n_log < 1024) begin
        log_addr[n_log] <= cfg.cfg_addr_o;
        log_rwn[n_log]  <= cfg.cfg_rwn_o;
        log_data[n_log] <= cfg.cfg_rwn_o ? cfg.cfg_data_i : cfg.cfg_data_o;
        log_cyc[n_log]  <= cyc;
        n_log <= n_log + 1;
      end
      if (cfg.cfg_rwn_o && cfg.cfg_addr_o == 5'h0D)
        tgt_rd <= tgt_rd + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic push_byte(input logic [7:0] b);
    tgt_bytes[tgt_wr & 63] = b;
    tgt_wr = tgt_wr + 1;
  endtask

  task automatic pulse_start();
    setup_i = 32'h0036_0006;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  function automatic int count_addr(input int from, input logic [4:0] a);
    int c = 0;
    for (int i = from; i < n_log && i < 1024; i++)
      if (log_addr[i] == a) c++;
    return c;
  endfunction

  task automatic test_reset();
    rstn_i = 1'b0;
    tick(3);
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_cmp++; if (cfg.cfg_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_valid: got %b want 0", cfg.cfg_valid_o); end
    n_cmp++; if (cfg.cfg_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_cfg_data: got %h want 0", cfg.cfg_data_o); end
    n_cmp++; if (rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid_o); end
    n_cmp++; if (fifo_level_o !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level_o); end
    n_cmp++; if ({err_parity_o, err_overflow_o} !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b want 00", {err_parity_o, err_overflow_o}); end
    rstn_i = 1'b1;
    tick(2);
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_setup();
    int base;
    base = n_log;
    pulse_start();
    n_cmp++; if (cfg.cfg_valid_o !== 1'b1) begin n_fail++; $display("FAIL setup_valid: got %b want 1", cfg.cfg_valid_o); end
    n_cmp++; if (cfg.cfg_addr_o !== 5'h09) begin n_fail++; $display("FAIL setup_addr: got %h want 09", cfg.cfg_addr_o); end
    n_cmp++; if (cfg.cfg_rwn_o !== 1'b0) begin n_fail++; $display("FAIL setup_rwn: got %b want 0", cfg.cfg_rwn_o); end
    n_cmp++; if (cfg.cfg_data_o !== 32'h0036_0216) begin n_fail++; $display("FAIL setup_data: got %h want 00360216", cfg.cfg_data_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL setup_busy: got %b want 1", busy_o); end
    tick(8);
    n_cmp++; if (log_addr[base] !== 5'h09 || log_rwn[base] !== 1'b0) begin n_fail++; $display("FAIL log_setup: got addr %h rwn %b want 09/0", log_addr[base], log_rwn[base]); end
    n_cmp++; if (log_addr[base+1] !== 5'h0C || log_addr[base+2] !== 5'h0C) begin n_fail++; $display("FAIL log_polls: got %h %h want 0c 0c", log_addr[base+1], log_addr[base+2]); end
    n_cmp++; if (log_cyc[base+2] - log_cyc[base+1] !== 3) begin n_fail++; $display("FAIL poll_spacing: got %0d want 3", log_cyc[base+2] - log_cyc[base+1]); end
    n_cmp++; if (log_cyc[base+1] - log_cyc[base] !== 3) begin n_fail++; $display("FAIL first_poll_spacing: got %0d want 3", log_cyc[base+1] - log_cyc[base]); end
  endtask

  task automatic test_single_byte();
    int base, idx, seen;
    bit got;
    rx_ready_i = 1'b0;
    base = n_log;
    push_byte(8'hA5);
    got = 0; seen = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk_i);
      if (rx_valid_o) begin got = 1; seen = cyc; end
    end
    n_cmp++; if (!got) begin n_fail++; $display("FAIL single_timeout: got no rx_valid want 1"); end
    idx = -1;
    for (int i = base; i < n_log; i++)
      if (idx < 0 && log_addr[i] == 5'h0D) idx = i;
    n_cmp++; if (idx <= base) begin n_fail++; $display("FAIL single_data_read: got idx %0d want >%0d", idx, base); end
    if (idx > base) begin
      n_cmp++; if (log_addr[idx-1] !== 5'h0C) begin n_fail++; $display("FAIL single_prev_valid: got %h want 0c", log_addr[idx-1]); end
      n_cmp++; if (seen !== log_cyc[idx] + 1) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", seen, log_cyc[idx] + 1); end
    end
    n_cmp++; if (rx_data_o !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", rx_data_o); end
    n_cmp++; if (fifo_level_o !== 3'd1) begin n_fail++; $display("FAIL single_level: got %0d want 1", fifo_level_o); end
    rx_ready_i = 1'b1;
    @(negedge clk_i);
    rx_ready_i = 1'b0;
    n_cmp++; if (fifo_level_o !== 3'd0 || rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_pop: got level %0d valid %b want 0/0", fifo_level_o, rx_valid_o); end
  endtask

  task automatic test_backpressure();
    int base, last, polls;
    logic [7:0] exp;
    rx_ready_i = 1'b0;
    base = n_log;
    for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i));
    tick(60);
    n_cmp++; if (count_addr(base, 5'h0D) !== 4) begin n_fail++; $display("FAIL bp_data_reads: got %0d want 4", count_addr(base, 5'h0D)); end
    n_cmp++; if (fifo_level_o !== 3'd4) begin n_fail++; $display("FAIL bp_level: got %0d want 4", fifo_level_o); end
    n_cmp++; if (rx_data_o !== 8'h10) begin n_fail++; $display("FAIL bp_head: got %h want 10", rx_data_o); end
    last = base;
    for (int i = base; i < n_log; i++)
      if (log_addr[i] == 5'h0D) last = i;
    polls = count_addr(last + 1, 5'h0C);
    n_cmp++; if ((polls >= 3) !== 1'b1) begin n_fail++; $display("FAIL bp_polls_when_full: got %0d want >=3", polls); end
    rx_ready_i = 1'b1;
    @(negedge clk_i);
    rx_ready_i = 1'b0;
    n_cmp++; if (rx_data_o !== 8'h11) begin n_fail++; $display("FAIL bp_after_pop: got %h want 11", rx_data_o); end
    tick(20);
    n_cmp++; if (count_addr(base, 5'h0D) !== 5) begin n_fail++; $display("FAIL bp_fifth_read: got %0d want 5", count_addr(base, 5'h0D)); end
    n_cmp++; if (fifo_level_o !== 3'd4) begin n_fail++; $display("FAIL bp_refill_level: got %0d want 4", fifo_level_o); end
    for (int i = 0; i < 4; i++) begin
      exp = 8'h11 + 8'(i);
      n_cmp++; if (rx_data_o !== exp) begin n_fail++; $display("FAIL bp_drain_%0d: got %h want %h", i, rx_data_o, exp); end
      rx_ready_i = 1'b1;
      @(negedge clk_i);
    end
    rx_ready_i = 1'b0;
    n_cmp++; if (fifo_level_o !== 3'd0) begin n_fail++; $display("FAIL bp_drained: got %0d want 0", fifo_level_o); end
  endtask

  task automatic test_err_disabled();
    int base;
    base = n_log;
    tgt_err   = 32'h3;
    err_clr_i = 1'b0;
    tick(70);
    n_cmp++; if (count_addr(0, 5'h0A) !== 0) begin n_fail++; $display("FAIL noerr_reads: got %0d want 0", count_addr(0, 5'h0A)); end
    n_cmp++; if ((count_addr(base, 5'h0C) >= 17) !== 1'b1) begin n_fail++; $display("FAIL noerr_polls: got %0d want >=17", count_addr(base, 5'h0C)); end
    n_cmp++; if ({err_parity_o, err_overflow_o} !== 2'b00) begin n_fail++; $display("FAIL noerr_flags: got %b want 00", {err_parity_o, err_overflow_o}); end
    tgt_err = 32'h0;
  endtask

  task automatic test_stop();
    int base;
    bit got;
    tgt_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk_i);
      if (cfg.cfg_valid_o && cfg.cfg_addr_o == 5'h0C) got = 1;
    end
    n_cmp++; if (!got) begin n_fail++; $display("FAIL stop_find_poll: got none want RD_VALID"); end
    tgt_ready = 1'b0;
    stop_i    = 1'b1;
    base = n_log;
    @(negedge clk_i);
    stop_i = 1'b0;
    n_cmp++; if (cfg.cfg_valid_o !== 1'b1 || cfg.cfg_addr_o !== 5'h0C) begin n_fail++; $display("FAIL stop_hold1: got %b/%h want 1/0c", cfg.cfg_valid_o, cfg.cfg_addr_o); end
    @(negedge clk_i);
    n_cmp++; if (cfg.cfg_valid_o !== 1'b1 || cfg.cfg_addr_o !== 5'h0C) begin n_fail++; $display("FAIL stop_hold2: got %b/%h want 1/0c", cfg.cfg_valid_o, cfg.cfg_addr_o); end
    @(negedge clk_i);
    tgt_ready = 1'b1;
    @(negedge clk_i);
    n_cmp++; if (cfg.cfg_addr_o !== 5'h09 || cfg.cfg_rwn_o !== 1'b0) begin n_fail++; $display("FAIL stop_wr_addr: got %h/%b want 09/0", cfg.cfg_addr_o, cfg.cfg_rwn_o); end
    n_cmp++; if (cfg.cfg_data_o !== 32'h0036_0006) begin n_fail++; $display("FAIL stop_wr_data: got %h want 00360006", cfg.cfg_data_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL stop_busy_hi: got %b want 1", busy_o); end
    @(negedge clk_i);
    n_cmp++; if (busy_o !== 1'b0 || cfg.cfg_valid_o !== 1'b0) begin n_fail++; $display("FAIL stop_idle: got busy %b valid %b want 0/0", busy_o, cfg.cfg_valid_o); end
    n_cmp++; if (n_log - base !== 2 || log_addr[base] !== 5'h0C || log_addr[base+1] !== 5'h09) begin n_fail++; $display("FAIL stop_log: got n %0d %h %h want 2 0c 09", n_log - base, log_addr[base], log_addr[base+1]); end
  endtask

  task automatic test_reset_mid();
    int base;
    bit got;
    tgt_ready  = 1'b1;
    rx_ready_i = 1'b0;
    push_byte(8'h5A);
    push_byte(8'h6B);
    pulse_start();
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk_i);
      if (rx_valid_o && cfg.cfg_valid_o && cfg.cfg_addr_o == 5'h0D) got = 1;
    end
    n_cmp++; if (!got) begin n_fail++; $display("FAIL rmid_find_data: got none want RD_DATA"); end
    tgt_ready = 1'b0;
    tick(2);
    #2 rstn_i = 1'b0;
    #1;
    n_cmp++; if (cfg.cfg_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", cfg.cfg_valid_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy_o); end
    n_cmp++; if (fifo_level_o !== 3'd0 || rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_fifo: got %0d/%b want 0/0", fifo_level_o, rx_valid_o); end
    @(negedge clk_i);
    rstn_i    = 1'b1;
    tgt_ready = 1'b1;
    @(negedge clk_i);
    base = n_log;
    pulse_start();
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk_i);
      if (rx_valid_o) got = 1;
    end
    n_cmp++; if (rx_data_o !== 8'h6B) begin n_fail++; $display("FAIL rmid_restart_data: got %h want 6b", rx_data_o); end
    n_cmp++; if (log_addr[base] !== 5'h09 || log_data[base] !== 32'h0036_0216) begin n_fail++; $display("FAIL rmid_restart_setup: got %h/%h want 09/00360216", log_addr[base], log_data[base]); end
    rx_ready_i = 1'b1;
    @(negedge clk_i);
    rx_ready_i = 1'b0;
  endtask

  task automatic test_err_poll();
    int base, idx, nerr;
    bit got;
    rstn_i = 1'b0;
    tick(2);
    rstn_i    = 1'b1;
    tgt_ready = 1'b1;
    tgt_err   = 32'h2;
    err_clr_i = 1'b0;
    @(negedge clk_i);
    base = n_log;
    pulse_start();
    got = 0; idx = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk_i);
      if (n_log > base && log_addr[n_log-1] == 5'h0A) begin
        got = 1; idx = n_log - 1;
      end
    end
    tgt_err = 32'h0;
    n_cmp++; if (!got) begin n_fail++; $display("FAIL err_timeout: got no 0a read want one"); end
    n_cmp++; if (idx < 0 || count_addr(base, 5'h0C) - count_addr(idx, 5'h0C) !== 16) begin n_fail++; $display("FAIL err_poll_count: got idx %0d want 16 polls before", idx); end
    n_cmp++; if (err_parity_o !== 1'b1 || err_overflow_o !== 1'b0) begin n_fail++; $display("FAIL err_flags: got %b%b want 10", err_parity_o, err_overflow_o); end
    tick(30);
    nerr = count_addr(base, 5'h0A);
    n_cmp++; if (nerr !== 1) begin n_fail++; $display("FAIL err_single_read: got %0d want 1", nerr); end
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    n_cmp++; if (err_parity_o !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", err_parity_o); end
    tgt_err   = 32'h2;
    err_clr_i = 1'b1;
    base = n_log;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk_i);
      if (n_log > base && log_addr[n_log-1] == 5'h0A) got = 1;
    end
    err_clr_i = 1'b0;
    tgt_err   = 32'h0;
    n_cmp++; if (!got || err_parity_o !== 1'b1) begin n_fail++; $display("FAIL err_set_wins: got found %b parity %b want 1/1", got, err_parity_o); end
  endtask

  initial begin
    rstn_i     = 1'b0;
    start_i    = 1'b0;
    stop_i     = 1'b0;
    setup_i    = 32'h0;
    rx_ready_i = 1'b0;
    err_clr_i  = 1'b0;
    tgt_ready  = 1'b1;
    tgt_err    = 32'h0;
    test_reset();
    test_setup();
    test_single_byte();
    test_backpressure();
`ifndef UART_POLL_ERR_EN
    test_err_disabled();
`endif
    test_stop();
    test_reset_mid();
`ifdef UART_POLL_ERR_EN
    test_err_poll();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
